// File: rtl/clock_pkg.sv
// Shared clock constants and the 12-hour display conversion used by the
// hour counter, the alarm comparator and the set logic.
package clock_pkg;

  localparam int HRS_PER_DAY = 24;
  localparam int HRS_W       = 7;

  typedef struct packed {
    logic        pm;
    logic [31:0] hrs;
  } disp12_t;

  // Converts a 0-based hour count (below 2*half) to the 12-hour display value.
  // Hour zero of each half-day is shown as half.
  function automatic disp12_t to_12h(input logic [31:0] cnt, input logic [31:0] half);
    disp12_t     d;
    logic [31:0] h;
    d.pm  = (cnt >= half);
    h     = d.pm ? (cnt - half) : cnt;
    d.hrs = (h == 32'd0) ? half : h;
    return d;
  endfunction

endpackage

// File: rtl/hour_display_map.sv
// Combinational map from an internal hour count and display mode to the
// displayed hour and the PM flag.
module hour_display_map
  import clock_pkg::*;
#(
  parameter int hrs_per_day_p = HRS_PER_DAY,
  parameter int width_p       = HRS_W
) (
  input  logic [width_p-1:0] i_cnt,
  input  logic               i_mode24,
  output logic [width_p-1:0] o_hrs,
  output logic               o_pm
);

  localparam logic [31:0] HALF = 32'(hrs_per_day_p / 2);

  disp12_t w_d;

  assign w_d   = to_12h(32'(i_cnt), HALF);
  assign o_pm  = w_d.pm;
  assign o_hrs = i_mode24 ? i_cnt : width_p'(w_d.hrs);

endmodule

// File: rtl/hour_counter_12_24.sv
// Hour register for the digital clock: advances on minute carries, accepts
// 12/24-hour switch loads and drives the hour display, PM flag and day carry.
module hour_counter_12_24
  import clock_pkg::*;
#(
  parameter int hrs_per_day_p = HRS_PER_DAY,
  parameter int width_p       = HRS_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               tick_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_hrs_i,
  input  logic               load_pm_i,
  input  logic               mode24_i,
  output logic [width_p-1:0] hrs_o,
  output logic               pm_o,
  output logic               day_carry_o,
  output logic               load_err_o
);

  localparam logic [width_p-1:0] HALF = width_p'(hrs_per_day_p / 2);
  localparam logic [width_p-1:0] LAST = width_p'(hrs_per_day_p - 1);
  localparam logic [width_p-1:0] DAY  = width_p'(hrs_per_day_p);

  logic [width_p-1:0] r_cnt;
  logic [width_p-1:0] r_hrs;
  logic               r_pm;
  logic               r_carry;
  logic               r_err;
  logic               r_rst_hold;

  logic [width_p-1:0] w_cnt_nxt;
  logic [width_p-1:0] w_load_val;
  logic               w_load_ok;
  logic               w_carry_nxt;
  logic               w_err_nxt;
  logic [width_p-1:0] w_hrs_nxt;
  logic               w_pm_nxt;

  // Load wins over tick; a tick in a load cycle is dropped even if the load is rejected.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (mode24_i) begin
      w_load_ok  = (load_hrs_i < DAY);
      w_load_val = load_hrs_i;
    end else begin
      w_load_ok  = (load_hrs_i != '0) && (load_hrs_i <= HALF);
      w_load_val = ((load_hrs_i == HALF) ? '0 : load_hrs_i) + (load_pm_i ? HALF : '0);
    end
    if (load_i) begin
      if (w_load_ok) begin
        w_cnt_nxt = w_load_val;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (tick_i) begin
      if (r_cnt == LAST) begin
        w_cnt_nxt   = '0;
        w_carry_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  hour_display_map #(
    .hrs_per_day_p (hrs_per_day_p),
    .width_p       (width_p)
  ) u_map (
    .i_cnt    (w_cnt_nxt),
    .i_mode24 (mode24_i),
    .o_hrs    (w_hrs_nxt),
    .o_pm     (w_pm_nxt)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt      <= '0;
      r_hrs      <= HALF;
      r_pm       <= 1'b0;
      r_carry    <= 1'b0;
      r_err      <= 1'b0;
      r_rst_hold <= 1'b1;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_hrs      <= w_hrs_nxt;
      r_pm       <= w_pm_nxt;
      r_carry    <= w_carry_nxt;
      r_err      <= w_err_nxt;
      r_rst_hold <= 1'b0;
    end
  end

  // Until the first edge after reset, the shown hour follows the current mode.
  assign hrs_o       = (reset_i || r_rst_hold) ? (mode24_i ? '0 : HALF) : r_hrs;
  assign pm_o        = r_pm;
  assign day_carry_o = r_carry;
  assign load_err_o  = r_err;

endmodule

// File: tb/tb_hour_counter_12_24.sv
// Bench for hour_counter_12_24: directed scenarios plus randomized traffic
// checked against an hour-of-day reference model.
module tb_hour_counter_12_24;

  localparam int W = 7;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         tick_i = 1'b0;
  logic         load_i = 1'b0;
  logic [W-1:0] load_hrs_i = '0;
  logic         load_pm_i = 1'b0;
  logic         mode24_i = 1'b0;
  logic [W-1:0] hrs_o;
  logic         pm_o;
  logic         day_carry_o;
  logic         load_err_o;

  int errors = 0;
  int checks = 0;

  int m_hour = 0;
  int exp_carry = 0;
  int exp_err = 0;

  hour_counter_12_24 #(.hrs_per_day_p(24), .width_p(W)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .tick_i      (tick_i),
    .load_i      (load_i),
    .load_hrs_i  (load_hrs_i),
    .load_pm_i   (load_pm_i),
    .mode24_i    (mode24_i),
    .hrs_o       (hrs_o),
    .pm_o        (pm_o),
    .day_carry_o (day_carry_o),
    .load_err_o  (load_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int disp(input int hour, input logic m24);
    if (m24) return hour;
    return ((hour % 12) == 0) ? 12 : (hour % 12);
  endfunction

  function automatic logic exp_pm(input int hour);
    return hour >= 12;
  endfunction

  // Applies one cycle of stimulus, advances the reference model, samples 1ns after the edge.
  task automatic do_cycle(input logic t, input logic l, input int v, input logic p, input logic m);
    bit ok;
    tick_i     = t;
    load_i     = l;
    load_hrs_i = W'(v);
    load_pm_i  = p;
    mode24_i   = m;
    exp_carry  = 0;
    exp_err    = 0;
    if (l) begin
      ok = m ? (v < 24) : (v >= 1 && v <= 12);
      if (ok) m_hour = m ? v : ((v % 12) + (p ? 12 : 0));
      else exp_err = 1;
    end else if (t) begin
      exp_carry = (m_hour == 23) ? 1 : 0;
      m_hour = (m_hour + 1) % 24;
    end
    @(posedge clk_i);
    #1;
    tick_i = 1'b0;
    load_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (hrs_o !== 7'd12) begin errors++; $display("FAIL reset_hrs_12h: got %0d expected 12", hrs_o); end
    checks++; if (pm_o !== 1'b0) begin errors++; $display("FAIL reset_pm: got %0b expected 0", pm_o); end
    checks++; if (day_carry_o !== 1'b0 || load_err_o !== 1'b0) begin errors++; $display("FAIL reset_pulses: got carry=%0b err=%0b expected 0 0", day_carry_o, load_err_o); end
    #3 reset_i = 1'b0;
    m_hour = 0;
    do_cycle(0, 0, 0, 0, 0);
    checks++; if (hrs_o !== 7'd12) begin errors++; $display("FAIL idle_12h: got %0d expected 12", hrs_o); end
    mode24_i = 1'b1;
    #1;
    checks++; if (hrs_o !== 7'd12) begin errors++; $display("FAIL mode_not_comb: got %0d expected 12", hrs_o); end
    do_cycle(0, 0, 0, 0, 1);
    checks++; if (hrs_o !== 7'd0) begin errors++; $display("FAIL mode24_after_edge: got %0d expected 0", hrs_o); end
  endtask

  task automatic test_tick_rollover;
    int carries = 0;
    do_cycle(0, 1, 12, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      do_cycle(1, 0, 0, 0, 0);
      checks++; if (int'(hrs_o) !== disp(m_hour, 0)) begin errors++; $display("FAIL tick_hrs[%0d]: got %0d expected %0d", i, hrs_o, disp(m_hour, 0)); end
      checks++; if (pm_o !== exp_pm(m_hour)) begin errors++; $display("FAIL tick_pm[%0d]: got %0b expected %0b", i, pm_o, exp_pm(m_hour)); end
      checks++; if (day_carry_o !== (i == 24)) begin errors++; $display("FAIL tick_carry[%0d]: got %0b expected %0b", i, day_carry_o, (i == 24)); end
      if (day_carry_o === 1'b1) carries++;
    end
    checks++; if (carries != 1) begin errors++; $display("FAIL carry_count: got %0d expected 1", carries); end
  endtask

  task automatic test_loads_12h;
    do_cycle(0, 1, 12, 0, 0);
    checks++; if (hrs_o !== 7'd12 || pm_o !== 1'b0) begin errors++; $display("FAIL load_12am: got %0d/%0b expected 12/0", hrs_o, pm_o); end
    do_cycle(0, 0, 0, 0, 1);
    checks++; if (hrs_o !== 7'd0) begin errors++; $display("FAIL 12am_in_24h: got %0d expected 0", hrs_o); end
    do_cycle(0, 1, 12, 1, 0);
    checks++; if (hrs_o !== 7'd12 || pm_o !== 1'b1) begin errors++; $display("FAIL load_12pm: got %0d/%0b expected 12/1", hrs_o, pm_o); end
    do_cycle(0, 0, 0, 0, 1);
    checks++; if (hrs_o !== 7'd12 || pm_o !== 1'b1) begin errors++; $display("FAIL 12pm_in_24h: got %0d/%0b expected 12/1", hrs_o, pm_o); end
  endtask

  task automatic test_load_errors;
    do_cycle(0, 1, 17, 0, 1);
    do_cycle(1, 1, 24, 0, 1);
    checks++; if (load_err_o !== 1'b1 || hrs_o !== 7'd17) begin errors++; $display("FAIL err_24: got err=%0b hrs=%0d expected 1 17", load_err_o, hrs_o); end
    checks++; if (day_carry_o !== 1'b0) begin errors++; $display("FAIL err_no_carry: got %0b expected 0", day_carry_o); end
    do_cycle(0, 0, 0, 0, 0);
    checks++; if (load_err_o !== 1'b0 || hrs_o !== 7'd5 || pm_o !== 1'b1) begin errors++; $display("FAIL err_one_cycle: got err=%0b hrs=%0d pm=%0b expected 0 5 1", load_err_o, hrs_o, pm_o); end
    do_cycle(0, 1, 0, 0, 0);
    checks++; if (load_err_o !== 1'b1 || hrs_o !== 7'd5) begin errors++; $display("FAIL err_0_12h: got err=%0b hrs=%0d expected 1 5", load_err_o, hrs_o); end
    do_cycle(0, 1, 13, 1, 0);
    checks++; if (load_err_o !== 1'b1 || hrs_o !== 7'd5) begin errors++; $display("FAIL err_13_12h: got err=%0b hrs=%0d expected 1 5", load_err_o, hrs_o); end
  endtask

  task automatic test_load_tick_collision;
    do_cycle(1, 1, 5, 0, 1);
    checks++; if (hrs_o !== 7'd5) begin errors++; $display("FAIL collide_load: got %0d expected 5", hrs_o); end
    do_cycle(1, 0, 0, 0, 1);
    checks++; if (hrs_o !== 7'd6) begin errors++; $display("FAIL tick_after_collide: got %0d expected 6", hrs_o); end
  endtask

  task automatic test_random;
    logic t, l, p, m;
    int v;
    for (int i = 0; i < 300; i++) begin
      l = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 2) != 0);
      p = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 7) == 0) ? ~mode24_i : mode24_i;
      v = $urandom_range(0, 30);
      do_cycle(t, l, v, p, m);
      checks++; if (int'(hrs_o) !== disp(m_hour, m) || pm_o !== exp_pm(m_hour)) begin errors++; $display("FAIL rand_disp[%0d]: got %0d/%0b expected %0d/%0b", i, hrs_o, pm_o, disp(m_hour, m), exp_pm(m_hour)); end
      checks++; if (day_carry_o !== 1'(exp_carry) || load_err_o !== 1'(exp_err)) begin errors++; $display("FAIL rand_pulses[%0d]: got carry=%0b err=%0b expected %0d %0d", i, day_carry_o, load_err_o, exp_carry, exp_err); end
    end
  endtask

  task automatic test_async_reset;
    do_cycle(0, 1, 17, 0, 1);
    checks++; if (hrs_o !== 7'd17) begin errors++; $display("FAIL pre_reset_17: got %0d expected 17", hrs_o); end
    #2;
    tick_i  = 1'b1;
    reset_i = 1'b1;
    #1;
    checks++; if (hrs_o !== 7'd0 || pm_o !== 1'b0 || day_carry_o !== 1'b0 || load_err_o !== 1'b0) begin errors++; $display("FAIL async_reset: got hrs=%0d pm=%0b carry=%0b err=%0b expected 0 0 0 0", hrs_o, pm_o, day_carry_o, load_err_o); end
    mode24_i = 1'b0;
    #1;
    checks++; if (hrs_o !== 7'd12) begin errors++; $display("FAIL reset_mode_follow: got %0d expected 12", hrs_o); end
    @(posedge clk_i);
    #1;
    tick_i   = 1'b0;
    mode24_i = 1'b1;
    reset_i  = 1'b0;
    m_hour   = 0;
    do_cycle(0, 0, 0, 0, 1);
    checks++; if (hrs_o !== 7'd0 || pm_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %0d/%0b expected 0/0", hrs_o, pm_o); end
    do_cycle(1, 0, 0, 0, 1);
    checks++; if (hrs_o !== 7'd1) begin errors++; $display("FAIL post_reset_tick: got %0d expected 1", hrs_o); end
  endtask

  initial begin
    test_reset;
    test_tick_rollover;
    test_loads_12h;
    test_load_errors;
    test_load_tick_collision;
    test_random;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hour_counter_12_24.md
# hour_counter_12_24

Parametrised hour register for the digital clock: holds the time-of-day hour as an internal 0-based count and advances it on a carry pulse from the minutes stage. It accepts switch loads in either 12-hour or 24-hour format, rejects out-of-range values, and drives the hour display with the 12-hour zero-hour mapping (internal 0 shown as 12). It sits between the minutes counter and the hour display/decoder and produces the PM flag and a day-rollover pulse.

## Interface
- hrs_per_day_p, 24, hours per day; must be even; half_p = hrs_per_day_p/2 is the 12-hour-mode terminal display value.
- width_p, 7, width of hour ports; width_p >= clog2(hrs_per_day_p + 1).

- clk_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- tick_i  input  1  one-cycle pulse: advance one hour.
- load_i  input  1  one-cycle pulse: load load_hrs_i.
- load_hrs_i  input  width_p  switch value, interpreted per mode24_i.
- load_pm_i  input  1  PM select for a 12-hour-mode load; ignored in 24-hour mode.
- mode24_i  input  1  1 = 24-hour display/load format, 0 = 12-hour.
- hrs_o  output  width_p  displayed hour, registered.
- pm_o  output  1  1 when internal count >= half_p, registered.
- day_carry_o  output  1  one-cycle pulse on wrap from hrs_per_day_p-1 to 0.
- load_err_o  output  1  one-cycle pulse: load rejected.

## Operation
- Internal state cnt, 0..hrs_per_day_p-1. Reset: cnt=0.
- Per-edge priority: load_i over tick_i; a tick coincident with a load is dropped, never deferred.
- Tick: cnt = cnt+1; at hrs_per_day_p-1, cnt = 0 and day_carry_o pulses.
- Load, 24-hour mode: valid when load_hrs_i < hrs_per_day_p; cnt = load_hrs_i.
- Load, 12-hour mode: valid when 1 <= load_hrs_i <= half_p. Value half_p maps to 0; otherwise load_hrs_i is kept. Add half_p when load_pm_i=1. So 12 AM gives cnt=0, and 12 PM gives cnt=half_p.
- Invalid load: cnt unchanged, load_err_o pulses, tick in the same cycle still dropped, day_carry_o stays 0.
- Display mapping, from next-state cnt:
  - 24-hour: hrs_o = cnt.
  - 12-hour: h = cnt mod half_p; hrs_o = half_p when h = 0, else h.
  - pm_o = (cnt >= half_p) in both modes.
- mode24_i is sampled every edge. A mode change alters hrs_o only, never cnt.

## Timing
- Reset outputs (asynchronous): hrs_o = 0 if mode24_i=1, else half_p (default 12); pm_o=0; day_carry_o=0; load_err_o=0. The mode-dependent hrs_o reset uses mode24_i combinationally during reset.
- Latency: hrs_o, pm_o, day_carry_o and load_err_o all update on the same edge that samples tick_i/load_i (1 cycle). No combinational input-to-output path except reset.
- A mode24_i change is visible on hrs_o one edge later.
- Back-to-back ticks on consecutive cycles are all counted.
- Reset mid-load or mid-tick: reset wins, and the pending event is lost.

## Structure
- Shared package clock_pkg holds:
  - HRS_PER_DAY (24) and HRS_W (7), reused by the alarm and set logic.
  - Function to_12h(cnt) returning the display value and PM flag.
- One sub-module: hour_display_map (combinational cnt + mode -> hrs_o and pm_o), instantiated on the next-state value. The alarm comparator reuses it.

## Test plan
- Reset with mode24_i=0 -> hrs_o=12, pm_o=0. Switch mode24_i=1 -> hrs_o=0 one edge later.
- 24 ticks from reset in 12-hour mode -> hrs_o sequence 1..11, 12 (pm_o=1), 1..11, then 12 (pm_o=0). day_carry_o pulses exactly once, on the 24th tick.
- 12-hour load of 12 with load_pm_i=0 -> hrs_o=12, pm_o=0. Switch to 24-hour -> hrs_o=0. Load 12 with load_pm_i=1 -> hrs_o=12, pm_o=1.
- Load 24 in 24-hour mode, and separately load 0 or 13 in 12-hour mode -> load_err_o pulses one cycle, hrs_o unchanged.
- load_i (value 5, 24-hour) together with tick_i -> hrs_o=5, not 6. The next lone tick gives 6.
- Assert reset_i asynchronously mid-count at hour 17 -> outputs return to their reset values before the next edge.
